div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle 32-bit integer divider for MIPS DIV/DIVU, instantiated in the EX stage.
//  It requests a pipeline hold through stop_o, which drives the controller's stop_from_ex.
//  It consumes the controller's flush and the downstream hold, so it is the stall requester
//  at the other end of the stall/flush interface. Results feed HI (remainder) and LO (quotient).
// PARAMETERS
//  DATA_W  32  operand/result width
//  CNT_W    5  iteration counter width; 2**CNT_W == DATA_W
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low (`RstEnable)
//  start      in   1       EX holds a DIV/DIVU; level, stays high while EX is stalled
//  signed_div in   1       1=DIV (two's complement), 0=DIVU
//  dividend   in   DATA_W  rs operand, sampled only on accept
//  divisor    in   DATA_W  rt operand, sampled only on accept
//  flush      in   1       controller flush_o; aborts any operation
//  ex_hold    in   1       downstream stall of EX (controller stall[4])
//  stop_o     out  1       `Stop while the division is unfinished; to stop_from_ex
//  done_o     out  1       quotient_o/remainder_o valid
//  quotient_o  out DATA_W  quotient, to LO
//  remainder_o out DATA_W  remainder, to HI
// BEHAVIOUR
//  Reset: state=IDLE; cnt, quotient_o, remainder_o, done_o=0; stop_o=0 (combinational).
//  FSM states: IDLE, BUSY, DONE.
//  - IDLE & start & !flush: accept. Latch |dividend|, |divisor|, q_neg, r_neg.
//    Go to DONE if divisor==0, else go to BUSY with cnt=0.
//  - BUSY: one restoring step per cycle: {rem,q}<<1; if rem>=div, then rem-=div, q[0]=1.
//    cnt++. After step cnt==DATA_W-1, go to DONE.
//  - DONE: done_o=1, outputs stable. Stay while ex_hold=1. Go to IDLE on the first cycle
//    with ex_hold=0 (EX advances that edge). An EX bubble cannot restart the old operation.
//  - Any state & flush: go to IDLE next edge; done_o cleared; no result delivered.
//  stop_o = !flush & ((IDLE & start) | BUSY). Low in DONE, which lets the controller release EX.
//  Latency: accept in cycle N; stop_o high for cycles N..N+32 (33 cycles); done_o at N+33.
//  Signed: operate on magnitudes. Negate the quotient if the operand signs differ.
//   The remainder takes the dividend's sign.
//   0x80000000 / -1 gives quotient 0x80000000, remainder 0 (natural wrap; no trap).
//  Divide by zero: quotient = all ones, remainder = dividend (raw). Latency 1 cycle (DONE at N+1).
//  start low in DONE: still return to IDLE on !ex_hold. Outputs hold until the next accept.
//  start while BUSY: ignored; operands are not resampled.
//  Reset mid-operation: immediate IDLE; all outputs return to reset values.
// STRUCTURE
//  defines.v gains `DivIdle / `DivBusy / `DivDone (2-bit encodings) and `DivWidth 32.
//   Reuse the existing `Stop / `NoStop / `RstEnable.
//  One sub-module: div_step (combinational) takes {rem,q}, div and returns the next {rem,q}.
//   Keeps the iteration testable standalone.
//  Sign fix-up and the FSM stay in div_unit.
// TESTING
//  1 DIVU 100/7, ex_hold=0 -> stop_o high 33 cycles; done_o at N+33; q=14, r=2.
//  2 DIV -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7/-2 -> q=0xFFFFFFFD, r=1.
//    DIV 0x80000000/-1 -> q=0x80000000, r=0.
//  3 DIVU 5/0 -> done_o at N+1; q=0xFFFFFFFF, r=5; stop_o high exactly 1 cycle.
//  4 flush pulse at cycle N+10 -> stop_o low that cycle; IDLE next edge; done_o never rises.
//    A new start at N+12 completes normally at N+45.
//  5 ex_hold=1 for 3 cycles after done -> done_o and outputs held 4 cycles, stop_o low;
//    IDLE after ex_hold drops.
//  6 rst low at N+5 -> stop_o, done_o, outputs 0 immediately; no completion after release.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle MIPS DIV/DIVU unit.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,q} left and conditionally subtract div.
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] div,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] q_next
);

  logic [DATA_W:0] shifted;

  always_comb begin
    shifted = {rem, q[DATA_W-1]};
    if (shifted >= {1'b0, div}) begin
      // The difference is below div, so the low DATA_W bits hold it exactly.
      rem_next = shifted[DATA_W-1:0] - div;
      q_next   = {q[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = shifted[DATA_W-1:0];
      q_next   = {q[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// EX-stage divider: holds the pipeline via stop_o while iterating, then presents
// quotient (LO) and remainder (HI) until EX advances.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_WIDTH,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stop_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output div_state_e        dbg_state
);

  div_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_r, q_r, div_r;
  logic [DATA_W-1:0] rem_n, q_n;
  logic              q_neg, r_neg;
  logic              accept, last_step;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sg);
    return (sg && v[DATA_W-1]) ? -v : v;
  endfunction

  assign accept    = (state == DIV_IDLE) && start && !flush;
  assign last_step = (state == DIV_BUSY) && (cnt == CNT_W'(DATA_W - 1));
  assign done_o    = (state == DIV_DONE);
  assign dbg_state = state;

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .div      (div_r),
    .rem_next (rem_n),
    .q_next   (q_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state <= DIV_IDLE;
    else                   state <= state_next;
  end

  always_comb begin
    state_next = state;
    stop_o     = NO_STOP;
    case (state)
      DIV_IDLE: if (accept) state_next = (divisor == '0) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (last_step) state_next = DIV_DONE;
      DIV_DONE: if (!ex_hold) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush) state_next = DIV_IDLE;
    // Dropping stop_o in DONE is what lets the controller release EX.
    if (rst != RST_ENABLE && !flush &&
        ((state == DIV_IDLE && start) || state == DIV_BUSY))
      stop_o = STOP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt         <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      div_r       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else if (accept) begin
      cnt   <= '0;
      rem_r <= '0;
      q_r   <= mag(dividend, signed_div);
      div_r <= mag(divisor, signed_div);
      q_neg <= signed_div && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      r_neg <= signed_div && dividend[DATA_W-1];
      if (divisor == '0) begin
        quotient_o  <= '1;
        remainder_o <= dividend;
      end
    end else if (state == DIV_BUSY && !flush) begin
      rem_r <= rem_n;
      q_r   <= q_n;
      cnt   <= cnt + 1'b1;
      if (last_step) begin
        quotient_o  <= q_neg ? -q_n : q_n;
        remainder_o <= r_neg ? -rem_n : rem_n;
      end
    end
  end

endmodule
